// File: rtl/preg_free_list_if.sv
// Rename/commit-side bundle for the physical-register free list.
// master = rename + ROB driving requests, slave = the free list itself.
interface preg_free_list_if #(
    parameter int PREG_W = 6
);
    logic              alloc_req;
    logic [PREG_W-1:0] alloc_preg;
    logic              alloc_gnt;
    logic              stall;
    logic [1:0]        rel_en;
    logic [PREG_W-1:0] rel_preg0;
    logic [PREG_W-1:0] rel_preg1;
    logic [5:0]        free_count;
    logic              dbl_free_err;

    modport master (
        output alloc_req, rel_en, rel_preg0, rel_preg1,
        input  alloc_preg, alloc_gnt, stall, free_count, dbl_free_err
    );

    modport slave (
        input  alloc_req, rel_en, rel_preg0, rel_preg1,
        output alloc_preg, alloc_gnt, stall, free_count, dbl_free_err
    );
endinterface

// File: rtl/preg_free_list.sv
// Circular free list of unmapped physical registers: one allocation per cycle
// from the head, up to two releases per cycle appended at the tail.
module preg_free_list #(
    parameter int NUM_PREG = 64,
    parameter int NUM_AREG = 32,
    parameter int PREG_W   = 6,
    parameter int DEPTH    = 32
) (
    input  logic             clk,
    input  logic             rstn,
    preg_free_list_if.slave  fl
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [NUM_PREG-1:0] IN_FREE_RST = ~((NUM_PREG)'(1) << NUM_AREG) + 1'b1 == '0
                                                  ? '0 : ~(((NUM_PREG)'(1) << NUM_AREG) - 1'b1);

    logic [PTR_W-1:0]    head_reg, head_next;
    logic [PTR_W-1:0]    tail_reg, tail_next;
    logic [5:0]          count_reg, count_next;
    logic [NUM_PREG-1:0] in_free_reg, in_free_next;
    logic                err_reg, err_next;

    logic [PREG_W-1:0]   slot [DEPTH];
    logic                gnt;
    logic [5:0]          cnt_alloc;
    logic                v0, v1, dup, bad0, bad1, acc0, acc1;
    logic [PTR_W-1:0]    wr1_idx;

    // Acceptance is decided against the pre-update bitmap and the count left
    // after this cycle's allocation; port 1 also sees port 0's accept.
    always_comb begin
        gnt       = fl.alloc_req && (count_reg != '0);
        cnt_alloc = count_reg - {5'b0, gnt};

        v0   = fl.rel_en[0] && (fl.rel_preg0 != '0);
        bad0 = v0 && (in_free_reg[fl.rel_preg0] || (cnt_alloc >= 6'(DEPTH)));
        acc0 = v0 && !bad0;

        v1   = fl.rel_en[1] && (fl.rel_preg1 != '0);
        dup  = fl.rel_en[0] && (fl.rel_preg1 == fl.rel_preg0);
        bad1 = v1 && (in_free_reg[fl.rel_preg1] || dup ||
                      ((cnt_alloc + {5'b0, acc0}) >= 6'(DEPTH)));
        acc1 = v1 && !bad1;

        wr1_idx    = tail_reg + PTR_W'(acc0);
        head_next  = head_reg + PTR_W'(gnt);
        tail_next  = tail_reg + PTR_W'(acc0) + PTR_W'(acc1);
        count_next = cnt_alloc + {5'b0, acc0} + {5'b0, acc1};
        err_next   = err_reg | bad0 | bad1;

        in_free_next = in_free_reg;
        if (gnt)  in_free_next[slot[head_reg]] = 1'b0;
        if (acc0) in_free_next[fl.rel_preg0]   = 1'b1;
        if (acc1) in_free_next[fl.rel_preg1]   = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            head_reg    <= '0;
            tail_reg    <= '0;
            count_reg   <= 6'(DEPTH);
            in_free_reg <= IN_FREE_RST;
            err_reg     <= 1'b0;
        end else begin
            head_reg    <= head_next;
            tail_reg    <= tail_next;
            count_reg   <= count_next;
            in_free_reg <= in_free_next;
            err_reg     <= err_next;
        end
    end

    // Each slot resets to its initial pReg and captures whichever port targets it.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic [PREG_W-1:0] slot_reg;
        always_ff @(posedge clk) begin
            if (!rstn)
                slot_reg <= PREG_W'(NUM_AREG + gi);
            else if (acc0 && (tail_reg == PTR_W'(gi)))
                slot_reg <= fl.rel_preg0;
            else if (acc1 && (wr1_idx == PTR_W'(gi)))
                slot_reg <= fl.rel_preg1;
        end
        assign slot[gi] = slot_reg;
    end

    assign fl.alloc_preg   = slot[head_reg];
    assign fl.alloc_gnt    = gnt;
    assign fl.stall        = (count_reg == '0);
    assign fl.free_count   = count_reg;
    assign fl.dbl_free_err = err_reg;
endmodule

// File: tb/tb_preg_free_list.sv
// Scoreboard bench for preg_free_list: directed vectors then a modelled random run.
module tb_preg_free_list;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    preg_free_list_if #(.PREG_W(6)) fl ();
    preg_free_list dut (.clk(clk), .rstn(rstn), .fl(fl));

    typedef struct {
        string    tag;
        bit       gnt;
        bit       chk_preg;
        int       preg;
        int       count;
        bit       err;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: outputs are sampled 2ns after the negedge where inputs changed.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.tag, ".gnt"},   int'(fl.alloc_gnt), int'(e.gnt));
                if (e.chk_preg) chk({e.tag, ".preg"}, int'(fl.alloc_preg), e.preg);
                chk({e.tag, ".count"}, int'(fl.free_count), e.count);
                chk({e.tag, ".stall"}, int'(fl.stall), int'(e.count == 0));
                chk({e.tag, ".err"},   int'(fl.dbl_free_err), int'(e.err));
                $display("vec %-8s gnt=%0d preg=%0d count=%0d err=%0d",
                         e.tag, fl.alloc_gnt, fl.alloc_preg, fl.free_count, fl.dbl_free_err);
            end
        end
    end

    task automatic step(input string tag, input bit req, input bit [1:0] en,
                        input int p0, input int p1, input bit egnt, input int epreg,
                        input int ecount, input bit eerr);
        exp_t e;
        @(negedge clk);
        fl.alloc_req = req;
        fl.rel_en    = en;
        fl.rel_preg0 = 6'(p0);
        fl.rel_preg1 = 6'(p1);
        e.tag = tag; e.gnt = egnt; e.chk_preg = (epreg >= 0); e.preg = epreg;
        e.count = ecount; e.err = eerr;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        fl.alloc_req = 1'b0; fl.rel_en = 2'b00; fl.rel_preg0 = '0; fl.rel_preg1 = '0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Reference model state for the random phase
    int  mq[$];
    int  held[$];
    bit  mfree [64];
    bit  merr;

    task automatic model_reset();
        mq.delete(); held.delete();
        for (int i = 0; i < 32; i++) mq.push_back(32 + i);
        for (int p = 0; p < 64; p++) mfree[p] = (p >= 32);
        for (int p = 1; p < 32; p++) held.push_back(p);
        merr = 1'b0;
    endtask

    task automatic drop_held(input int p);
        for (int i = 0; i < held.size(); i++)
            if (held[i] == p) begin held.delete(i); break; end
    endtask

    initial begin
        rstn = 1'b0;
        fl.alloc_req = 1'b0; fl.rel_en = 2'b00; fl.rel_preg0 = '0; fl.rel_preg1 = '0;
        do_reset();

        // Drain: 32 grants in order, then empty
        for (int i = 0; i < 32; i++)
            step("drain", 1, 2'b00, 0, 0, 1, 32 + i, 32 - i, 0);
        step("empty", 1, 2'b00, 0, 0, 0, -1, 0, 0);

        // Two-wide release from empty, FIFO order
        step("rel2",   0, 2'b11, 5, 40, 0, -1, 0, 0);
        step("al5",    1, 2'b00, 0, 0,  1, 5,  2, 0);
        step("al40",   1, 2'b00, 0, 0,  1, 40, 1, 0);
        // No bypass: release into empty does not grant this cycle
        step("nobyp",  1, 2'b01, 7, 0,  0, -1, 0, 0);
        step("al7",    1, 2'b00, 0, 0,  1, 7,  1, 0);
        step("empty2", 0, 2'b00, 0, 0,  0, -1, 0, 0);

        // p0 ignored silently, p12 accepted
        step("p0rel",  0, 2'b11, 0, 12, 0, -1, 0, 0);
        step("p0chk",  0, 2'b00, 0, 0,  0, 12, 1, 0);
        step("al12",   1, 2'b00, 0, 0,  1, 12, 1, 0);

        // Same pReg on both ports: one accepted, error raised
        step("dup9",   0, 2'b11, 9, 9,  0, -1, 0, 0);
        step("dupchk", 0, 2'b00, 0, 0,  0, 9,  1, 1);
        step("al9",    1, 2'b00, 0, 0,  1, 9,  1, 1);
        step("sticky", 0, 2'b00, 0, 0,  0, -1, 0, 1);

        // After reset: already-free p33 dropped, error sticky
        do_reset();
        step("rst",    0, 2'b01, 33, 0, 0, 32, 32, 0);
        step("dblchk", 0, 2'b00, 0, 0,  0, 32, 32, 1);
        step("al32",   1, 2'b00, 0, 0,  1, 32, 32, 1);
        // Overflow: at count 31 only one of two legal releases fits
        step("ovf",    0, 2'b11, 32, 5, 0, 33, 31, 1);
        step("ovfchk", 1, 2'b00, 0, 0,  1, 33, 32, 1);

        // Random phase against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            bit       req, gnt, a0, a1;
            bit [1:0] en;
            int       p0, p1, cnt, hd;
            req = ($urandom_range(0, 99) < 55);
            en  = 2'($urandom_range(0, 3));
            p0  = (held.size() > 0 && $urandom_range(0, 9) != 0)
                  ? held[$urandom_range(0, held.size() - 1)] : int'($urandom_range(0, 63));
            p1  = (held.size() > 0 && $urandom_range(0, 9) != 0)
                  ? held[$urandom_range(0, held.size() - 1)] : int'($urandom_range(0, 63));
            gnt = req && (mq.size() != 0);
            hd  = (mq.size() != 0) ? mq[0] : -1;
            step("rand", req, en, p0, p1, gnt, hd, mq.size(), merr);

            cnt = mq.size() - int'(gnt);
            a0 = 0; a1 = 0;
            if (en[0] && p0 != 0) begin
                if (mfree[p0] || cnt >= 32) merr = 1;
                else begin a0 = 1; cnt++; end
            end
            if (en[1] && p1 != 0) begin
                if (mfree[p1] || (en[0] && p1 == p0) || cnt >= 32) merr = 1;
                else a1 = 1;
            end
            if (gnt) begin
                void'(mq.pop_front());
                mfree[hd] = 0;
                held.push_back(hd);
            end
            if (a0) begin mq.push_back(p0); mfree[p0] = 1; drop_held(p0); end
            if (a1) begin mq.push_back(p1); mfree[p1] = 1; drop_held(p1); end
        end

        // Let the monitor drain, bounded
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        @(negedge clk);
        #4;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end
endmodule
